// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the fetch-ahead instruction queue: FSM encoding and
// default bus widths.
package if_pkg;
    typedef enum logic {
        IF_IDLE     = 1'b0,
        IF_WAIT_MEM = 1'b1
    } if_state_t;

    localparam int DEF_INST_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int INST_BYTES     = 4;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// Cache-side request/response and decode-side valid/ready bundle. master is
// the fetch unit; slave is the cache/decode environment around it.
interface inst_fetch_queue_if
    import if_pkg::*;
#(
    parameter int INST_WIDTH = DEF_INST_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  inst_cache_read_valid;
    logic [ADDR_WIDTH-1:0] inst_cache_read_addr;
    logic                  inst_cache_read_done;
    logic [INST_WIDTH-1:0] inst_cache_read_data;
    logic                  inst_decode_valid;
    logic                  inst_decode_ready;
    logic [INST_WIDTH-1:0] inst_decode_data;
    logic [ADDR_WIDTH-1:0] inst_decode_pc;

    modport master (
        output inst_cache_read_valid, inst_cache_read_addr,
        input  inst_cache_read_done, inst_cache_read_data,
        output inst_decode_valid, inst_decode_data, inst_decode_pc,
        input  inst_decode_ready
    );

    modport slave (
        input  inst_cache_read_valid, inst_cache_read_addr,
        output inst_cache_read_done, inst_cache_read_data,
        input  inst_decode_valid, inst_decode_data, inst_decode_pc,
        output inst_decode_ready
    );
endinterface

// File: rtl/inst_fetch_queue_queue.sv
// Synchronous FIFO holding {pc, instruction} entries; flush drops everything
// by snapping head to tail.
module inst_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DEF_INST_WIDTH + DEF_ADDR_WIDTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [PW:0]      count,
    output logic [WIDTH-1:0] head_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail;

    // Storage is cleared on reset so the head reads zero before any push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    assign head_data = mem[head];
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch-ahead unit: one outstanding cache request, PC-tagged instruction queue
// toward decode, and redirect handling that flushes and squashes in-flight data.
module inst_fetch_queue
    import if_pkg::*;
#(
    parameter int                    INST_WIDTH  = DEF_INST_WIDTH,
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    inst_fetch_queue_if.master    bus
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int EW = INST_WIDTH + ADDR_WIDTH;

    if_state_t             state;
    logic [ADDR_WIDTH-1:0] fetch_pc, req_addr;
    logic                  discard;
    logic [CW-1:0]         count;
    logic [EW-1:0]         head;
    logic                  issue, push, pop, flush, done;

    assign done  = bus.inst_cache_read_done;
    // rst gates the strobe so no request escapes while reset is asserted.
    assign issue = rst && rdy && (state == IF_IDLE) && !redirect_valid &&
                   (count < CW'(QUEUE_DEPTH));
    assign push  = rdy && (state == IF_WAIT_MEM) && done && !discard && !redirect_valid;
    assign pop   = rdy && bus.inst_decode_valid && bus.inst_decode_ready;
    assign flush = rdy && redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IF_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            discard  <= 1'b0;
        end else if (rdy) begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~ADDR_WIDTH'(INST_BYTES - 1);
                if (state == IF_WAIT_MEM) begin
                    if (done) begin
                        state   <= IF_IDLE;
                        discard <= 1'b0;
                    end else begin
                        discard <= 1'b1;
                    end
                end
            end else begin
                case (state)
                    IF_IDLE: if (issue) begin
                        state    <= IF_WAIT_MEM;
                        req_addr <= fetch_pc;
                    end
                    IF_WAIT_MEM: if (done) begin
                        state   <= IF_IDLE;
                        discard <= 1'b0;
                        if (!discard) fetch_pc <= fetch_pc + ADDR_WIDTH'(INST_BYTES);
                    end
                endcase
            end
        end
    end

    inst_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(EW)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data ({fetch_pc, bus.inst_cache_read_data}),
        .count     (count),
        .head_data (head)
    );

    // Address stays on the outstanding request even if a redirect moves fetch_pc.
    assign bus.inst_cache_read_valid = issue;
    assign bus.inst_cache_read_addr  = (state == IF_WAIT_MEM) ? req_addr : fetch_pc;
    assign bus.inst_decode_valid     = (count != '0);
    assign bus.inst_decode_pc        = head[EW-1:INST_WIDTH];
    assign bus.inst_decode_data      = head[INST_WIDTH-1:0];
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed and randomized checks of inst_fetch_queue against a queue-level
// reference model and a variable-latency cache model.
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    inst_fetch_queue_if bus ();

    inst_fetch_queue #(.QUEUE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fetch;
    bit          m_out, m_disc;
    bit          c_busy;
    int          c_left;
    logic [31:0] c_addr, c_data;
    int          lat, slow_lat;
    logic [31:0] slow_addr;
    bit          hash_data, ready_on_done, redir_on_done, did_redir;
    logic [31:0] redir_target;
    int          cyc, first_dv_cyc;
    logic [31:0] req_log[$];
    int          req_cyc[$];
    int          ntests = 0;
    int          nfail  = 0;

    function automatic logic [31:0] word_for(input logic [31:0] a);
        return hash_data ? ((a * 32'h9E3779B1) ^ 32'hA5A50013) : 32'h13;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_read_valid", bus.inst_cache_read_valid, 0);
        chk("rst_read_addr",  bus.inst_cache_read_addr, 0);
        chk("rst_dec_valid",  bus.inst_decode_valid, 0);
        chk("rst_dec_data",   bus.inst_decode_data, 0);
        chk("rst_dec_pc",     bus.inst_decode_pc, 0);
        rdy = 0; redirect_valid = 0; redirect_pc = '0;
        bus.inst_cache_read_done = 0; bus.inst_cache_read_data = '0;
        bus.inst_decode_ready = 0;
        mq.delete(); m_fetch = '0; m_out = 0; m_disc = 0; c_busy = 0;
        req_log.delete(); req_cyc.delete(); first_dv_cyc = -1; cyc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: drive inputs, check at negedge, advance the model, step the edge.
    task automatic cycle(input bit rdy_v, input bit ready_v, input bit redir_v,
                         input logic [31:0] rpc);
        ent_t e;
        bit   dn, rv, pop;
        rdy = rdy_v;
        bus.inst_cache_read_done = 0;
        if (rdy_v && c_busy && c_left <= 1) begin
            bus.inst_cache_read_done = 1;
            bus.inst_cache_read_data = c_data;
        end
        dn = bus.inst_cache_read_done;
        bus.inst_decode_ready = ready_on_done ? dn : ready_v;
        redirect_valid = redir_v || (redir_on_done && dn && bus.inst_decode_valid);
        redirect_pc    = redir_v ? rpc : redir_target;
        did_redir      = redirect_valid;
        @(negedge clk);

        chk("dec_valid", bus.inst_decode_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("dec_pc",   bus.inst_decode_pc,   mq[0].pc);
            chk("dec_data", bus.inst_decode_data, mq[0].data);
        end
        rv = bus.inst_cache_read_valid;
        chk("read_valid", rv, rdy && !m_out && mq.size() < DEPTH && !redirect_valid);
        if (rv)    chk("read_addr", bus.inst_cache_read_addr, m_fetch);
        if (m_out) chk("read_addr_held", bus.inst_cache_read_addr, c_addr);
        if (mq.size() != 0 && first_dv_cyc < 0) first_dv_cyc = cyc;

        if (rdy) begin
            pop = (mq.size() != 0) && bus.inst_decode_ready;
            if (redirect_valid) begin
                mq.delete();
                m_fetch = redirect_pc & ~32'h3;
                if (m_out) begin
                    if (dn) begin m_out = 0; m_disc = 0; end
                    else m_disc = 1;
                end
            end else begin
                if (pop) void'(mq.pop_front());
                if (dn) begin
                    if (!m_disc) begin
                        e.pc = m_fetch; e.data = c_data;
                        mq.push_back(e);
                        m_fetch += 32'd4;
                    end
                    m_out = 0; m_disc = 0;
                end
                if (rv) m_out = 1;
            end
            if (dn) c_busy = 0;
            else if (c_busy) c_left--;
            if (rv) begin
                c_busy = 1;
                c_addr = bus.inst_cache_read_addr;
                c_left = (c_addr == slow_addr) ? slow_lat : lat;
                c_data = word_for(c_addr);
                req_log.push_back(c_addr);
                req_cyc.push_back(cyc);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_req(input int max_cyc, input bit ready_v);
        int  n0 = req_log.size();
        bit  seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            cycle(1, ready_v, 0, '0);
            seen = (req_log.size() > n0);
        end
        chk("req_seen", seen, 1);
    endtask

    initial begin
        logic [31:0] s_addr, s_pc, s_data;
        logic        s_dv;
        bit          got;
        bus.inst_cache_read_done = 0; bus.inst_cache_read_data = '0;
        bus.inst_decode_ready = 0;
        lat = 1; slow_addr = 32'hFFFFFFFF; slow_lat = 1;
        hash_data = 0; ready_on_done = 0; redir_on_done = 0; redir_target = '0;

        // Streaming with a 1-cycle cache.
        do_reset();
        repeat (10) cycle(1, 1, 0, '0);
        chk("stream_req0", req_log[0], 32'h0);
        chk("stream_req1", req_log[1], 32'h4);
        chk("stream_req2", req_log[2], 32'h8);
        chk("stream_gap1", req_cyc[1] - req_cyc[0], 2);
        chk("stream_gap2", req_cyc[2] - req_cyc[1], 2);
        chk("first_dv_lat", first_dv_cyc - req_cyc[0], 2);

        // Decode stalled: queue fills, then one pop frees a slot.
        do_reset();
        repeat (16) cycle(1, 0, 0, '0);
        chk("full_nreq", req_log.size(), 4);
        chk("full_last", req_log[3], 32'hC);
        chk("full_pc", bus.inst_decode_pc, 32'h0);
        cycle(1, 1, 0, '0);
        cycle(1, 0, 0, '0);
        chk("refill_nreq", req_log.size(), 5);
        chk("refill_addr", req_log[4], 32'h10);

        // Redirect while waiting on a slow response.
        do_reset();
        slow_addr = 32'h8; slow_lat = 4;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(1, 1, 0, '0);
            got = (req_log.size() >= 3);
        end
        chk("slow_req_seen", got, 1);
        cycle(1, 1, 1, 32'h103);
        run_until_req(10, 1);
        chk("redir_addr", req_log[req_log.size()-1], 32'h100);
        chk("redir_empty", bus.inst_decode_valid, 0);
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            cycle(1, 0, 0, '0);
            got = bus.inst_decode_valid;
        end
        chk("redir_dv", got, 1);
        chk("redir_first_pc", bus.inst_decode_pc, 32'h100);
        slow_addr = 32'hFFFFFFFF;

        // Redirect coincident with done and a pop.
        do_reset();
        lat = 2; hash_data = 1;
        repeat (10) cycle(1, 0, 0, '0);
        ready_on_done = 1; redir_on_done = 1; redir_target = 32'h200;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(1, 0, 0, '0);
            got = did_redir;
        end
        ready_on_done = 0; redir_on_done = 0;
        chk("coinc_fired", got, 1);
        chk("coinc_dv", bus.inst_decode_valid, 0);
        run_until_req(10, 0);
        chk("coinc_addr", req_log[req_log.size()-1], 32'h200);

        // Global stall mid-stream.
        do_reset();
        lat = 1;
        repeat (5) cycle(1, 0, 0, '0);
        cycle(0, 1, 0, '0);
        s_addr = bus.inst_cache_read_addr; s_dv = bus.inst_decode_valid;
        s_pc = bus.inst_decode_pc; s_data = bus.inst_decode_data;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, 32'h40);
            chk("stall_rv",   bus.inst_cache_read_valid, 0);
            chk("stall_addr", bus.inst_cache_read_addr, s_addr);
            chk("stall_dv",   bus.inst_decode_valid, s_dv);
            chk("stall_pc",   bus.inst_decode_pc, s_pc);
            chk("stall_data", bus.inst_decode_data, s_data);
        end
        repeat (6) cycle(1, 1, 0, '0);

        // Asynchronous reset while a request is outstanding.
        do_reset();
        lat = 3;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(1, 0, 0, '0);
            got = (req_log.size() >= 2) && m_out;
        end
        chk("async_wait", got, 1);
        chk("async_pre_addr", bus.inst_cache_read_addr, 32'h4);
        do_reset();
        run_until_req(10, 1);
        chk("async_first_req", req_log[0], 32'h0);

        // Randomized traffic, including redirects near the top of the space.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            lat = 1 + int'($urandom_range(0, 2));
            cycle(($urandom % 10) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0,
                  ($urandom % 2) ? $urandom : (32'hFFFFFFF0 | ($urandom % 16)));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
